// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - register map, STATUS layout and pulse-engine states for the PIO output block
package pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLEAR     = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE    = 3'd3;
  localparam logic [2:0] ADDR_PULSE     = 3'd4;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_CNT_LSB  = 16;
  localparam int STATUS_CNT_W    = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/pio_pulse_timer.sv
// rtl/pio_pulse_timer.sv - one-shot down-counter with load, cancel, expiry detect and busy
module pio_pulse_timer
  import pio_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 cancel_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 busy_o,
  output logic                 expire_o
);

  pulse_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          state_d = ST_ACTIVE;
          cnt_d   = load_val_i;
        end
      end
      ST_ACTIVE: begin
        // A reload on the last cycle suppresses expiry so the pulse continues glitch-free.
        if (cnt_q == CNT_WIDTH'(1) && !load_i) begin
          expire_o = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
        if (load_i) begin
          cnt_d = load_val_i;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (cancel_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign busy_o  = (cnt_q != '0);

endmodule

// File: rtl/avalon_pio_out_ext.sv
// rtl/avalon_pio_out_ext.sv - Avalon-MM output PIO with atomic set/clear/toggle and one-shot pulses
module avalon_pio_out_ext
  import pio_pkg::*;
#(
  parameter int                   WIDTH         = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE   = '0,
  parameter int                   CNT_WIDTH     = 16,
  parameter logic [CNT_WIDTH-1:0] PULSE_DEFAULT = CNT_WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_busy
);

  logic                 wr, rd;
  logic [WIDTH-1:0]     wd;
  logic [WIDTH-1:0]     out_q, out_d, mask_q, mask_d;
  logic [CNT_WIDTH-1:0] len_q, len_d, load_val, cnt;
  logic [31:0]          rdata_q, rdata_d, cnt_ext;
  logic                 pulse_load, cancel, busy, expire;
  logic                 unused_bits;

  assign wr         = chipselect & ~write_n;
  assign rd         = chipselect & ~read_n;
  assign wd         = writedata[WIDTH-1:0];
  assign pulse_load = wr && (address == ADDR_PULSE) && (wd != '0);
  assign cancel     = wr && (address == ADDR_DATA);
  assign load_val   = (len_q == '0) ? CNT_WIDTH'(1) : len_q;
  assign cnt_ext    = 32'(cnt);

  pio_pulse_timer #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (pulse_load),
    .load_val_i(load_val),
    .cancel_i  (cancel),
    .count_o   (cnt),
    .busy_o    (busy),
    .expire_o  (expire)
  );

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    len_d  = len_q;
    // Expiry lands first so a same-edge bus write has the final say.
    if (expire) begin
      out_d  = out_q & ~mask_q;
      mask_d = '0;
    end
    if (wr) begin
      case (address)
        ADDR_DATA: begin
          out_d  = wd;
          mask_d = '0;
        end
        ADDR_SET:    out_d = out_d | wd;
        ADDR_CLEAR: begin
          out_d  = out_d & ~wd;
          mask_d = mask_d & ~wd;
        end
        ADDR_TOGGLE: out_d = out_d ^ wd;
        ADDR_PULSE: begin
          out_d  = out_d | wd;
          mask_d = mask_d | wd;
        end
        ADDR_PULSE_LEN: len_d = writedata[CNT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (address)
        ADDR_DATA:      rdata_d = 32'(out_q);
        ADDR_PULSE_LEN: rdata_d = 32'(len_q);
        ADDR_STATUS: begin
          rdata_d[STATUS_CNT_LSB +: STATUS_CNT_W] = cnt_ext[STATUS_CNT_W-1:0];
          rdata_d[STATUS_BUSY_BIT]                = busy;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= RESET_VALUE;
      mask_q  <= '0;
      len_q   <= PULSE_DEFAULT;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      rdata_q <= rdata_d;
    end
  end

  assign unused_bits = ^{writedata, cnt_ext};
  assign readdata    = rdata_q;
  assign out_port    = out_q;
  assign pulse_busy  = busy;

endmodule

// File: tb/tb_avalon_pio_out_ext.sv
// tb/tb_avalon_pio_out_ext.sv - scoreboard bench for avalon_pio_out_ext against a behavioural model
module tb_avalon_pio_out_ext;

  localparam logic [7:0] RV = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect, write_n, read_n;
  logic [31:0] writedata, readdata;
  logic [7:0]  out_port;
  logic        pulse_busy;

  avalon_pio_out_ext #(
    .WIDTH        (8),
    .RESET_VALUE  (RV),
    .CNT_WIDTH    (16),
    .PULSE_DEFAULT(16'd1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .read_n    (read_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .pulse_busy(pulse_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  out;
    logic        busy;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: output value, bits owned by the pulse, cycles of pulse remaining, programmed length.
  logic [7:0] m_out, m_mask;
  int         m_rem, m_len;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("out_port", 32'(out_port), 32'(mon_e.out));
      chk("pulse_busy", 32'(pulse_busy), 32'(mon_e.busy));
      chk("readdata", readdata, mon_e.rdata);
    end
  end

  task automatic cycle(input logic rst, input logic cs, input logic wn, input logic rn,
                       input logic [2:0] a, input logic [31:0] d);
    exp_t       e;
    logic [7:0] w;
    logic       wr_s, rd_s, start;
    reset      = rst;
    chipselect = cs;
    write_n    = wn;
    read_n     = rn;
    address    = a;
    writedata  = d;
    w          = d[7:0];
    wr_s       = cs & ~wn;
    rd_s       = cs & ~rn;
    e.rdata    = 32'h0;
    if (rst) begin
      m_out  = RV;
      m_mask = 8'h00;
      m_rem  = 0;
      m_len  = 1;
    end else begin
      if (rd_s) begin
        case (a)
          3'd0: e.rdata = {24'h0, m_out};
          3'd5: e.rdata = 32'(m_len);
          3'd6: e.rdata = {m_rem[15:0], 15'h0, (m_rem != 0)};
          default: e.rdata = 32'h0;
        endcase
      end
      start = wr_s && (a == 3'd4) && (w != 8'h00);
      if (m_rem == 1 && !start) begin
        m_out  = m_out & ~m_mask;
        m_mask = 8'h00;
        m_rem  = 0;
      end else if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end
      if (wr_s) begin
        case (a)
          3'd0: begin m_out = w; m_mask = 8'h00; m_rem = 0; end
          3'd1: m_out = m_out | w;
          3'd2: begin m_out = m_out & ~w; m_mask = m_mask & ~w; end
          3'd3: m_out = m_out ^ w;
          3'd4: if (start) begin
            m_out  = m_out | w;
            m_mask = m_mask | w;
            m_rem  = (m_len == 0) ? 1 : m_len;
          end
          3'd5: m_len = int'(d[15:0]);
          default: ;
        endcase
      end
    end
    e.out  = m_out;
    e.busy = (m_rem != 0);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic rdr(input logic [2:0] a);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    address = 3'd0; writedata = 32'h0;
    m_out = RV; m_mask = 8'h00; m_rem = 0; m_len = 1;

    do_reset(2);
    rdr(3'd0); rdr(3'd6); rdr(3'd5); rdr(3'd7); idle(1);

    wr(3'd0, 32'h0F); wr(3'd1, 32'hF0); wr(3'd2, 32'h03); wr(3'd3, 32'h81);
    wr(3'd0, 32'hFFFF_FF00); rdr(3'd0); idle(1);

    wr(3'd5, 32'd5); wr(3'd0, 32'h0); wr(3'd4, 32'h04);
    for (int i = 0; i < 6; i++) rdr(3'd6);
    idle(2);

    wr(3'd5, 32'd3); wr(3'd4, 32'h01); idle(2); wr(3'd4, 32'h02); idle(5);

    wr(3'd5, 32'd10); wr(3'd4, 32'h10); idle(1); wr(3'd2, 32'h10); idle(10);
    wr(3'd4, 32'h10); idle(1); wr(3'd0, 32'h33); rdr(3'd6); idle(2);

    wr(3'd5, 32'd8); wr(3'd4, 32'h01); idle(3); do_reset(1); rdr(3'd6); idle(1);
    wr(3'd5, 32'd0); wr(3'd4, 32'h01); idle(3);
    wr(3'd4, 32'h0); wr(3'd7, 32'hFF); wr(3'd6, 32'hFF); rdr(3'd0);

    for (int i = 0; i < 800; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      logic        cs, wn, rn, rst;
      a   = 3'($urandom_range(0, 7));
      cs  = ($urandom_range(0, 7) != 0);
      wn  = $urandom_range(0, 1) == 1;
      rn  = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 99) == 0);
      d   = $urandom;
      if (a == 3'd5) d = $urandom_range(0, 6);
      else if (a == 3'd4 && $urandom_range(0, 3) == 0) d = 32'h0;
      cycle(rst, cs, wn, rn, a, d);
    end
    idle(2);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
